// File: rtl/video_pkg.sv
// Shared types and constants for the APF video output path.
// Pure declarations: no logic, no latency, no backpressure.
package video_pkg;

  typedef logic [2:0] scaler_slot_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Upper 21 bits of the end-of-line word; the slot fills the low 3 bits.
  localparam logic [20:0] EOL_ZERO_MSB = 21'd0;

  localparam int unsigned HS_VS_GAP_DEFAULT = 3;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/video_if.sv
// Pixel stream between video stages: rgb, data enable and level syncs.
// Wires only: no latency, no backpressure.
interface video_if;
  import video_pkg::*;

  rgb_t rgb;
  logic de;
  logic hs;
  logic vs;

  modport source (output rgb, de, hs, vs);
  modport sink   (input  rgb, de, hs, vs);
endinterface

// File: rtl/sync_pulse.sv
// Normalises a sync to active-high and flags its asserting edge for one cycle.
// Pulse is combinational on the sample that asserts; no backpressure.
module sync_pulse #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sync_i,
  output logic pulse_o
);

  logic lvl;
  logic lvl_q;

  assign lvl = sync_i ~^ ACTIVE_HIGH;

  always_ff @(posedge clk_i) begin
    if (reset_i) lvl_q <= 1'b0;
    else         lvl_q <= lvl;
  end

  assign pulse_o = lvl & ~lvl_q;

endmodule

// File: rtl/video_apf_output.sv
// APF scaler pin driver: registered RGB/DE, single-cycle HS/VS, EOL slot word, geometry stats.
// Latency 1 clk on every pin; free-running pixel stream, no backpressure.
module video_apf_output
  import video_pkg::*;
#(
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned HS_VS_GAP        = HS_VS_GAP_DEFAULT,
  parameter int unsigned PIX_W            = 12,
  parameter int unsigned LINE_W           = 11
) (
  input  logic              clk,
  input  logic              reset,
  video_if.sink             video_in,
  input  scaler_slot_t      scaler_slot,
  output logic [23:0]       video_rgb,
  output logic              video_de,
  output logic              video_hs,
  output logic              video_vs,
  output logic [PIX_W-1:0]  pixels_per_line,
  output logic [LINE_W-1:0] lines_per_frame,
  output logic              frame_done
);

  localparam int unsigned      GAP_W   = $clog2(HS_VS_GAP + 1) + 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(HS_VS_GAP);

  logic hs_edge;
  logic vs_edge;

  sync_pulse #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_hs_pulse (
    .clk_i   (clk),
    .reset_i (reset),
    .sync_i  (video_in.hs),
    .pulse_o (hs_edge)
  );

  sync_pulse #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_vs_pulse (
    .clk_i   (clk),
    .reset_i (reset),
    .sync_i  (video_in.vs),
    .pulse_o (vs_edge)
  );

  logic              de_prev_q;
  scaler_slot_t      slot_q,    slot_d;
  logic [GAP_W-1:0]  gap_q,     gap_d;
  logic              hs_pend_q, hs_pend_d;
  logic              seen_vs_q, seen_vs_d;
  logic [PIX_W-1:0]  pix_q,     pix_d;
  logic [LINE_W-1:0] line_q,    line_d;

  logic [23:0]       rgb_q,  rgb_d;
  logic              de_q,   de_d;
  logic              hs_q,   hs_d;
  logic              vs_q,   vs_d;
  logic [PIX_W-1:0]  ppl_q,  ppl_d;
  logic [LINE_W-1:0] lpf_q,  lpf_d;
  logic              fd_q,   fd_d;

  logic              de;
  logic              de_fall;
  logic              hs_req;
  logic              gap_ok;
  logic              line_done;
  logic [PIX_W-1:0]  pix_inc;
  logic [LINE_W-1:0] line_inc;

  always_comb begin
    de        = video_in.de;
    de_fall   = ~de & de_prev_q;
    hs_req    = hs_edge | hs_pend_q;
    // A VS edge this cycle restarts the gap, so the stale counter must not release HS.
    gap_ok    = ~vs_edge & (gap_q >= GAP_MAX);
    pix_inc   = (&pix_q)  ? pix_q  : pix_q  + PIX_W'(1);
    line_inc  = (&line_q) ? line_q : line_q + LINE_W'(1);
    line_done = de_fall & seen_vs_q & (pix_q != '0);

    slot_d    = slot_q;
    gap_d     = gap_q;
    seen_vs_d = seen_vs_q | vs_edge;
    pix_d     = pix_q;
    line_d    = line_q;
    ppl_d     = ppl_q;
    lpf_d     = lpf_q;

    de_d      = de;
    vs_d      = vs_edge;
    hs_d      = hs_req & gap_ok;
    hs_pend_d = hs_req & ~gap_ok;
    fd_d      = vs_edge & seen_vs_q;

    if (de) begin
      rgb_d = pack_rgb(video_in.rgb.red, video_in.rgb.green, video_in.rgb.blue);
    end else if (de_prev_q) begin
      rgb_d = {EOL_ZERO_MSB, slot_q};
    end else begin
      rgb_d = 24'h0;
    end

    if (vs_edge) begin
      gap_d  = GAP_W'(1);
      slot_d = scaler_slot;
    end else if (gap_q < GAP_MAX) begin
      gap_d  = gap_q + GAP_W'(1);
    end

    // Pixels only accumulate once a VS has opened a measured frame.
    if (de_fall) begin
      pix_d = '0;
    end else if (de && (seen_vs_q || vs_edge)) begin
      pix_d = pix_inc;
    end

    if (line_done) ppl_d = pix_q;

    if (vs_edge) begin
      line_d = '0;
      if (seen_vs_q) lpf_d = line_done ? line_inc : line_q;
    end else if (line_done) begin
      line_d = line_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_prev_q <= 1'b0;
      slot_q    <= '0;
      gap_q     <= '0;
      hs_pend_q <= 1'b0;
      seen_vs_q <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ppl_q     <= '0;
      lpf_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      de_prev_q <= de;
      slot_q    <= slot_d;
      gap_q     <= gap_d;
      hs_pend_q <= hs_pend_d;
      seen_vs_q <= seen_vs_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ppl_q     <= ppl_d;
      lpf_q     <= lpf_d;
      fd_q      <= fd_d;
    end
  end

  assign video_rgb       = rgb_q;
  assign video_de        = de_q;
  assign video_hs        = hs_q;
  assign video_vs        = vs_q;
  assign pixels_per_line = ppl_q;
  assign lines_per_frame = lpf_q;
  assign frame_done      = fd_q;

endmodule

// File: tb/tb_video_apf_output.sv
// Drives an active-high and an active-low instance with the same timing and checks both
// against an event-level model of the pin behaviour and frame geometry.
module tb_video_apf_output;
  import video_pkg::*;

  localparam int GAP = 3;

  logic         clk;
  logic         reset;
  scaler_slot_t slot;

  video_if vin_h ();
  video_if vin_l ();

  logic [23:0] rgb_h, rgb_l;
  logic        de_h, de_l, hs_h, hs_l, vs_h, vs_l, fd_h, fd_l;
  logic [11:0] ppl_h, ppl_l;
  logic [10:0] lpf_h, lpf_l;

  video_apf_output #(.SYNC_ACTIVE_HIGH(1'b1), .HS_VS_GAP(GAP), .PIX_W(12), .LINE_W(11)) dut_h (
    .clk(clk), .reset(reset), .video_in(vin_h), .scaler_slot(slot),
    .video_rgb(rgb_h), .video_de(de_h), .video_hs(hs_h), .video_vs(vs_h),
    .pixels_per_line(ppl_h), .lines_per_frame(lpf_h), .frame_done(fd_h));

  video_apf_output #(.SYNC_ACTIVE_HIGH(1'b0), .HS_VS_GAP(GAP), .PIX_W(12), .LINE_W(11)) dut_l (
    .clk(clk), .reset(reset), .video_in(vin_l), .scaler_slot(slot),
    .video_rgb(rgb_l), .video_de(de_l), .video_hs(hs_l), .video_vs(vs_l),
    .pixels_per_line(ppl_l), .lines_per_frame(lpf_l), .frame_done(fd_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: previous input levels, slot, HS schedule, frame statistics.
  logic        m_prev_de, m_prev_hs, m_prev_vs, m_seen;
  logic [2:0]  m_slot;
  int          m_run, m_lines, m_due, m_last_vs;
  logic [23:0] e_rgb;
  logic        e_de, e_hs, e_vs, e_fd;
  int          e_ppl, e_lpf;

  // Observations of the active-high instance used by the directed checks.
  int          n_fd = 0;
  int          vs_t = 0;
  int          hs_gap = -1;
  bit          gap_armed = 1'b0;
  logic        obs_de_prev = 1'b0;
  logic [23:0] last_eol = 24'hFFFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input string n, input logic [23:0] rgb, input logic de,
                           input logic hs, input logic vs, input logic [11:0] ppl,
                           input logic [10:0] lpf, input logic fd);
    check({n, "_rgb"}, 32'(rgb), 32'(e_rgb));
    check({n, "_de"},  32'(de),  32'(e_de));
    check({n, "_hs"},  32'(hs),  32'(e_hs));
    check({n, "_vs"},  32'(vs),  32'(e_vs));
    check({n, "_ppl"}, 32'(ppl), e_ppl);
    check({n, "_lpf"}, 32'(lpf), e_lpf);
    check({n, "_fd"},  32'(fd),  32'(e_fd));
  endtask

  task automatic model(input logic r, input logic d, input logic h, input logic v,
                       input logic [23:0] px);
    logic vs_rise, hs_rise, fall;
    if (r) begin
      m_prev_de = 0; m_prev_hs = 0; m_prev_vs = 0; m_seen = 0; m_slot = 0;
      m_run = 0; m_lines = 0; m_due = -1; m_last_vs = cyc + 1;
      e_rgb = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_ppl = 0; e_lpf = 0;
    end else begin
      vs_rise = v & ~m_prev_vs;
      hs_rise = h & ~m_prev_hs;
      fall    = ~d & m_prev_de;
      e_rgb   = d ? px : (m_prev_de ? {21'd0, m_slot} : 24'd0);
      e_de    = d;
      e_vs    = vs_rise;
      e_fd    = vs_rise & m_seen;
      if (vs_rise) begin
        m_last_vs = cyc;
        if (m_due >= 0 && m_due < cyc + GAP) m_due = cyc + GAP;
      end
      if (hs_rise && m_due < 0) m_due = (cyc > m_last_vs + GAP) ? cyc : m_last_vs + GAP;
      e_hs = (m_due == cyc);
      if (e_hs) m_due = -1;
      if (fall && m_seen && m_run > 0) begin
        e_ppl = m_run;
        if (m_lines < 2047) m_lines++;
      end
      if (fall) m_run = 0;
      if (vs_rise) begin
        if (m_seen) e_lpf = m_lines;
        m_lines = 0;
        m_seen  = 1;
        m_slot  = slot;
      end
      if (d && m_seen && m_run < 4095) m_run++;
      m_prev_de = d; m_prev_hs = h; m_prev_vs = v;
    end
  endtask

  task automatic step(input logic r, input logic d, input logic h, input logic v,
                      input logic [23:0] px);
    reset     = r;
    vin_h.de  = d;  vin_h.hs = h;  vin_h.vs = v;  vin_h.rgb = px;
    vin_l.de  = d;  vin_l.hs = ~h; vin_l.vs = ~v; vin_l.rgb = px;
    model(r, d, h, v, px);
    @(posedge clk);
    #1;
    check_dut("hi", rgb_h, de_h, hs_h, vs_h, ppl_h, lpf_h, fd_h);
    check_dut("lo", rgb_l, de_l, hs_l, vs_l, ppl_l, lpf_l, fd_l);
    if (fd_h) n_fd++;
    if (vs_h) begin vs_t = cyc; gap_armed = 1'b1; end
    else if (hs_h && gap_armed) begin hs_gap = cyc - vs_t; gap_armed = 1'b0; end
    if (obs_de_prev && !de_h) last_eol = rgb_h;
    obs_de_prev = de_h;
    cyc++;
  endtask

  function automatic logic [23:0] rnd();
    return 24'($urandom);
  endfunction

  task automatic line(input int len, input logic v, input bit fixed);
    for (int i = 0; i < 8; i++)   step(0, 0, 1, v, rnd());
    for (int i = 0; i < 4; i++)   step(0, 0, 0, v, rnd());
    for (int i = 0; i < len; i++) step(0, 1, 0, v, fixed ? 24'h123456 : rnd());
    for (int i = 0; i < 4; i++)   step(0, 0, 0, v, rnd());
  endtask

  task automatic vsync(input bit lead);
    hs_gap = -1;
    if (lead) step(0, 0, 0, 1, rnd());
    line(0, 1, 0);
    line(0, 1, 0);
  endtask

  task automatic lines(input int n, input int len);
    for (int i = 0; i < n; i++) line(len, 0, 0);
  endtask

  initial begin
    int fd_before;
    slot = 3'd0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, rnd());

    // Frame 1: full-width first line with fixed colour; first VS is not reported.
    vsync(0);
    check("fd_first_vs", 32'(n_fd), 32'd0);
    line(640, 0, 1);
    check("ppl_line1", 32'(ppl_h), 32'd640);
    lines(479, 4);

    // Frame 2: HS one cycle after VS; slot change mid-frame must wait for the next VS.
    vsync(1);
    check("hs_gap_lead", 32'(hs_gap), 32'd3);
    check("fd_count_f2", 32'(n_fd), 32'd1);
    check("lpf_f2", 32'(lpf_h), 32'd480);
    line(640, 0, 0);
    lines(200, 4);
    slot = 3'd5;
    lines(279, 4);
    check("eol_old_slot", 32'(last_eol), 32'h0);

    // Frame 3: HS and VS together; slot 5 now live.
    vsync(0);
    check("hs_gap_same", 32'(hs_gap), 32'd3);
    check("fd_count_f3", 32'(n_fd), 32'd2);
    check("lpf_f3", 32'(lpf_h), 32'd480);
    line($urandom_range(1, 48), 0, 0);
    check("eol_new_slot", 32'(last_eol), 32'h000005);
    for (int i = 0; i < 9; i++) line($urandom_range(1, 48), 0, 0);

    // Frame 4: random slot and short random geometry.
    slot = 3'($urandom);
    vsync(0);
    check("lpf_f4", 32'(lpf_h), 32'd10);
    for (int i = 0; i < 6; i++) line($urandom_range(1, 32), 0, 0);

    // Reset at pixel 300 of a line, then two full frames.
    for (int i = 0; i < 8; i++)   step(0, 0, 1, 0, rnd());
    for (int i = 0; i < 4; i++)   step(0, 0, 0, 0, rnd());
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, rnd());
    for (int i = 0; i < 4; i++)   step(1, 1, 0, 0, rnd());
    check("rst_rgb", 32'(rgb_h), 32'h0);
    check("rst_ppl", 32'(ppl_h), 32'h0);
    for (int i = 0; i < 336; i++) step(0, 1, 0, 0, rnd());
    for (int i = 0; i < 4; i++)   step(0, 0, 0, 0, rnd());
    check("ppl_after_rst", 32'(ppl_h), 32'd0);
    fd_before = n_fd;
    vsync(0);
    check("fd_skip_after_rst", 32'(n_fd), 32'(fd_before));
    line(640, 0, 0);
    lines(479, 4);
    vsync(0);
    check("fd_after_rst", 32'(n_fd), 32'(fd_before + 1));
    check("lpf_after_rst", 32'(lpf_h), 32'd480);
    line(640, 0, 0);
    check("ppl_after_rst2", 32'(ppl_h), 32'd640);
    lines(479, 4);

    // Over-long line saturates the pixel counter.
    vsync(0);
    check("lpf_before_sat", 32'(lpf_h), 32'd480);
    line(5000, 0, 0);
    check("ppl_sat", 32'(ppl_h), 32'd4095);
    vsync(0);
    check("lpf_one_line", 32'(lpf_h), 32'd1);

    // Random stress: arbitrary de/hs/vs patterns, slot changes and one short reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) slot = 3'($urandom);
      step((i >= 1500 && i < 1503), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 40) == 0), rnd());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
